// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the fetch controller
// Contents:
//   fetch_state_e  : controller FSM states
//   FETCH_ADDR_W   : default PC / instruction-memory address width
//   FETCH_DATA_W   : default instruction word width
//   FETCH_CNT_W    : default performance counter width (FETCH_PERF_EN builds)
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned FETCH_CNT_W  = 32;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - pair of wrapping event counters for fetch performance monitoring
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   fetch_inc           : count one consumed instruction this cycle
//   stall_inc           : count one memory wait cycle this cycle
//   fetch_cnt/stall_cnt : current counts, wrap modulo 2^CNT_W
module fetch_perf_cnt
  import fetch_pkg::*;
#(
  parameter int unsigned CNT_W = FETCH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc) fetch_cnt_d = fetch_cnt_q + 1'b1;
    if (stall_inc) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller between the PC register and decode
// Optional feature macro: FETCH_PERF_EN (adds perf_fetch_cnt / perf_stall_cnt)
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   pc_in                     : current PC from the PC register
//   pc_ena                    : PC register enable, (inst_valid & inst_ready) | flush
//   flush                     : redirect, drops fetched or in-flight instruction
//   imem_req/imem_addr        : level read request and its registered address
//   imem_ack/imem_rdata       : one-cycle response strobe and data
//   inst_valid/inst_out/inst_pc/inst_ready : handshake towards decode
//   perf_fetch_cnt/perf_stall_cnt : event counters (FETCH_PERF_EN only)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
`ifdef FETCH_PERF_EN
  ,
  parameter int unsigned CNT_W  = FETCH_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ena,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_fetch_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  // REQ is entered on the same edge that updates the PC register, so the
  // first REQ cycle (imem_req_q=0) samples the settled pc_in and raises the
  // request; a flush in that cycle moves the PC again, so issue is deferred.
  always_comb begin
    state_d      = state_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!imem_req_q) begin
          if (!flush) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_in;
          end
        end else if (imem_ack) begin
          imem_req_d = 1'b0;
          if (!flush) begin
            inst_out_d   = imem_rdata;
            inst_pc_d    = imem_addr_q;
            inst_valid_d = 1'b1;
            state_d      = VALID;
          end
        end else if (flush) begin
          // The request cannot be withdrawn; wait out its ack in DROP.
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = REQ;
        end
      end
      VALID: begin
        if (flush || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign pc_ena     = (inst_valid_q & inst_ready) | flush;
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_EN
  fetch_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk),
    .rst      (rst),
    .fetch_inc(inst_valid_q & inst_ready & ~flush),
    .stall_inc(imem_req_q & ~imem_ack),
    .fetch_cnt(perf_fetch_cnt),
    .stall_cnt(perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized self-checking bench for fetch_ctrl with PC register and memory models
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] POISON   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, flush, inst_ready, imem_ack;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_ena, imem_req, inst_valid;
  logic [31:0] imem_addr, inst_out, inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_ena    (pc_ena),
    .flush     (flush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_out  (inst_out),
    .inst_pc   (inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a fixed word at the reset vector, an
  // address-derived pattern elsewhere that can never equal POISON.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2408_0001;
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // Environment / reference model state
  logic [31:0] pc_tb, exp_pc, redirect, prev_addr, prev_deliver_addr;
  logic        prev_req, prev_deliver, prev_flush, poison;
  int          lat, req_age, cyc, hs_cycle, hs_gap, hs_count, idle_cnt;
  logic [31:0] fetch_m, stall_m;

  task automatic settle();
    #1;
  endtask

  // One clock cycle: memory response, checks of the observable rules,
  // model update, then advance to the next falling edge.
  task automatic cycle();
    bit hand;
    imem_ack   = imem_req && (req_age + 1 >= lat);
    imem_rdata = imem_ack ? ((poison || flush) ? POISON : mem_word(imem_addr)) : $urandom;
    #1;
    hand = !rst && inst_valid && inst_ready && !flush;
    if (!rst) begin
      check("pc_ena", pc_ena, (inst_valid && inst_ready) || flush);
      check("valid_req_excl", inst_valid & imem_req, 0);
      if (prev_req && imem_req) check("addr_stable", imem_addr, prev_addr);
      if (!prev_req && imem_req) check("req_addr", imem_addr, exp_pc);
      if (prev_deliver) begin
        check("valid_after_ack", inst_valid, 1);
        check("inst_pc_latch", inst_pc, prev_deliver_addr);
      end
      if (prev_flush) check("valid_after_flush", inst_valid, 0);
      if (inst_valid) check("inst_data", inst_out, mem_word(inst_pc));
      if (hand) check("inst_pc_seq", inst_pc, exp_pc);
      check("progress", idle_cnt > 40, 0);
`ifdef FETCH_PERF_EN
      check("perf_fetch", perf_fetch_cnt, fetch_m);
      check("perf_stall", perf_stall_cnt, stall_m);
`endif
    end
    if (rst) begin
      pc_tb = RESET_PC; exp_pc = RESET_PC; req_age = 0; poison = 0;
      prev_req = 0; prev_deliver = 0; prev_flush = 0;
      fetch_m = 0; stall_m = 0; idle_cnt = 0;
    end else begin
      if (pc_ena) pc_tb = flush ? redirect : pc_tb + 4;
      if (flush) exp_pc = redirect;
      else if (hand) exp_pc = exp_pc + 4;
      fetch_m = fetch_m + (hand ? 1 : 0);
      stall_m = stall_m + ((imem_req && !imem_ack) ? 1 : 0);
      prev_deliver      = imem_req && imem_ack && !flush && !poison;
      prev_deliver_addr = imem_addr;
      prev_flush = flush;
      prev_req   = imem_req;
      prev_addr  = imem_addr;
      if (!imem_req || imem_ack) begin
        req_age = 0; poison = 0;
      end else begin
        req_age++;
        if (flush) poison = 1;
      end
      if (hand) begin
        hs_gap = cyc - hs_cycle; hs_cycle = cyc; hs_count++;
      end
      idle_cnt = (hand || flush) ? 0 : idle_cnt + 1;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    pc_in = pc_tb;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !inst_valid; i++) cycle();
    check("wait_valid", inst_valid, 1);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !imem_req; i++) cycle();
    check("wait_req", imem_req, 1);
  endtask

  initial begin
    int c0;
    logic [31:0] pf_before;
    rst = 1; flush = 0; inst_ready = 0; imem_ack = 0; imem_rdata = 0;
    redirect = 0; lat = 2; pc_tb = RESET_PC; pc_in = RESET_PC; exp_pc = RESET_PC;
    prev_addr = 0; prev_deliver_addr = 0; prev_req = 0; prev_deliver = 0;
    prev_flush = 0; poison = 0; req_age = 0; cyc = 0; hs_cycle = 0; hs_gap = 0;
    hs_count = 0; idle_cnt = 0; fetch_m = 0; stall_m = 0; pf_before = 0;
    @(negedge clk);

    // Reset and first fetch
    cycle(); cycle();
    rst = 0;
    settle();
    check("rst_valid", inst_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_out", inst_out, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_pc_ena", pc_ena, 0);
    wait_valid(12);
    check("first_out", inst_out, 32'h2408_0001);
    check("first_pc", inst_pc, RESET_PC);

    // Decode backpressure
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_valid", inst_valid, 1);
      check("bp_out", inst_out, 32'h2408_0001);
      check("bp_pc_ena", pc_ena, 0);
      check("bp_req", imem_req, 0);
      cycle();
    end
    inst_ready = 1;
    settle();
    check("pop_pc_ena", pc_ena, 1);
    cycle();
    inst_ready = 0;
    settle();
    check("pop_pc_ena_once", pc_ena, 0);
    wait_req(10);
    check("next_addr", imem_addr, 32'h0040_0004);

    // Flush in VALID together with inst_ready
    wait_valid(12);
`ifdef FETCH_PERF_EN
    pf_before = perf_fetch_cnt;
`endif
    flush = 1; inst_ready = 1; redirect = 32'h0040_0100;
    settle();
    check("flush_pc_ena", pc_ena, 1);
    cycle();
    flush = 0; inst_ready = 0;
    settle();
    check("flush_drop_valid", inst_valid, 0);
`ifdef FETCH_PERF_EN
    check("flush_nocount", perf_fetch_cnt, pf_before);
`endif
    lat = 4;
    wait_req(10);
    check("redirect_addr", imem_addr, 32'h0040_0100);

    // Flush while the request is outstanding; its ack returns POISON
    flush = 1; redirect = 32'h0040_0200;
    cycle();
    flush = 0;
    for (int i = 0; i < 10 && imem_req; i++) begin
      settle();
      check("drop_addr_hold", imem_addr, 32'h0040_0100);
      cycle();
    end
    check("drop_req_done", imem_req, 0);
    lat = 2;
    wait_req(10);
    check("drop_redirect", imem_addr, 32'h0040_0200);
    wait_valid(12);
    check("post_drop_data", inst_out, mem_word(32'h0040_0200));

    // Zero-wait memory, decode always ready
    lat = 1; inst_ready = 1;
    c0 = hs_count;
    for (int i = 0; i < 15; i++) cycle();
    check("zw_count", hs_count - c0, 5);
    check("zw_gap", hs_gap, 3);

    // Five fetches with two-cycle ack, then reset in the middle of a request
    rst = 1; cycle(); rst = 0;
    lat = 2; inst_ready = 1;
    c0 = hs_count;
    for (int i = 0; i < 60 && (hs_count - c0) < 5; i++) cycle();
    check("five_fetches", hs_count - c0, 5);
`ifdef FETCH_PERF_EN
    check("perf_fetch_5", perf_fetch_cnt, 5);
    check("perf_stall_5", perf_stall_cnt, 5);
`endif
    cycle(); cycle();
    check("mid_req", imem_req, 1);
    rst = 1; cycle(); rst = 0;
    settle();
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", inst_valid, 0);
`ifdef FETCH_PERF_EN
    check("perf_fetch_rst", perf_fetch_cnt, 0);
    check("perf_stall_rst", perf_stall_cnt, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (!imem_req) lat = $urandom_range(1, 4);
      inst_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      if (flush) redirect = $urandom & 32'hFFFF_FFFC;
      rst        = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 0; flush = 0;
    check("random_progress", hs_count > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller directly downstream of the PC register.
- Takes the current PC from pcreg data_out and issues a request/acknowledge read to instruction memory.
- Registers the returned instruction with its PC and hands it to decode over a valid/ready handshake.
- Drives the PC register's enable, so the PC advances only when an instruction is consumed or a redirect (flush) occurs.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address
- DATA_W, 32, width of instruction word
- CNT_W, 32, width of performance counters (used only with FETCH_PERF_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  ADDR_W  current PC from PC register output
- pc_ena  out  1  enable to PC register; combinational: (inst_valid & inst_ready) | flush
- flush  in  1  redirect from later stage; drops any fetched or in-flight instruction
- imem_req  out  1  memory read request, level, held until ack
- imem_addr  out  ADDR_W  request address, registered, stable while imem_req=1
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid in the same cycle
- imem_rdata  in  DATA_W  instruction data
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction
- inst_out  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  PC of inst_out
- inst_ready  in  1  decode accepts the instruction this cycle

Behaviour:
- All state updates on rising clk. rst is sampled synchronously and overrides all other inputs.
- Reset values:
  - state=IDLE, imem_req=0, imem_addr=0
  - inst_valid=0, inst_out=0, inst_pc=0
  - pc_ena evaluates to 0 because inst_valid=0, assuming flush=0
- States:
  - IDLE: unconditional move to REQ next cycle. This cycle lets pcreg settle after reset. imem_req=0.
  - REQ:
    - Entering REQ latches imem_addr<=pc_in and sets imem_req=1.
    - On imem_ack with flush=0: inst_out<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, imem_req<=0, go VALID.
    - On flush=0 without ack: stay in REQ.
    - On flush=1 without ack: go DROP, with imem_req kept 1 and imem_addr unchanged. The memory protocol forbids abandoning a request.
    - On flush=1 and imem_ack in the same cycle: discard data, go REQ again (re-latch imem_addr<=pc_in on the next entry).
  - DROP:
    - Hold the request until imem_ack. On ack, discard imem_rdata and go REQ, latching the redirected pc_in.
    - A further flush in DROP is absorbed: stay in DROP.
  - VALID:
    - inst_valid=1.
    - On inst_ready=1: pc_ena=1 this cycle, so pcreg captures the next PC at this edge. Then inst_valid<=0, go REQ.
    - On flush=1: inst_valid<=0, go REQ. pc_ena=1 loads the redirect target. flush wins over inst_ready, and the instruction is not counted as consumed.
    - On inst_ready=0 with flush=0: hold all outputs stable.
- REQ entry after VALID or DROP occurs one cycle after the PC update, so imem_addr sees the new pc_in.
- Latency:
  - From REQ entry: ack on cycle N gives inst_valid on cycle N+1.
  - Minimum handoff-to-handoff throughput is 3 cycles with zero-wait memory: REQ, VALID, then REQ again.
- Invariants:
  - inst_valid and imem_req are never both 1.
  - imem_addr never changes while imem_req=1.
- imem_ack outside REQ/DROP is ignored.
- Reset mid-request: the outstanding request is abandoned. The memory model must tolerate this, and its late ack lands in IDLE and is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetch_cnt [CNT_W] and perf_stall_cnt [CNT_W], both reset to 0.
  - perf_fetch_cnt increments on each inst_valid&inst_ready&~flush.
  - perf_stall_cnt increments on each cycle with imem_req=1 & imem_ack=0.
  - Both counters wrap modulo 2^CNT_W.
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - state encoding (IDLE=2'd0, REQ=2'd1, VALID=2'd2, DROP=2'd3)
  - default ADDR_W/DATA_W constants
- Sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_EN. It is a two-counter block with inc inputs.

Test Plan:
- Reset and first fetch: rst=1 for 2 cycles, pc_in=32'h0040_0000, ack the request 2 cycles later with rdata=32'h2408_0001 -> imem_addr=32'h0040_0000; inst_valid=1 with inst_out=32'h2408_0001, inst_pc=32'h0040_0000.
- Decode backpressure: inst_ready=0 for 4 cycles -> inst_valid/inst_out stable, pc_ena=0, imem_req=0. Then inst_ready=1 -> pc_ena=1 for exactly one cycle, next imem_addr=32'h0040_0004.
- Flush in VALID with inst_ready=1 simultaneously -> inst_valid drops, pc_ena=1, next imem_addr equals the redirect pc_in (32'h0040_0100), and perf_fetch_cnt does not increment.
- Flush while a request is outstanding, ack 3 cycles later with rdata=32'hDEAD_BEEF -> imem_addr stays constant until ack, 32'hDEAD_BEEF never appears on inst_out, and a new request issues at the redirected PC.
- Zero-wait memory (ack in the first REQ cycle), inst_ready=1 always -> one instruction per 3 cycles; the inst_pc sequence is +4 each.
- With FETCH_PERF_EN: 5 fetches with 2-cycle ack latency each -> perf_fetch_cnt=5, perf_stall_cnt=5. rst mid-run -> both counters read 0 the next cycle.
